// File: rtl/conv_window_sequencer_pkg.sv
// rtl/conv_window_sequencer_pkg.sv - shared constants and FSM encoding for the 3x3 window sequencer
package conv_window_sequencer_pkg;

    // Default counter width; largest frame dimension is 2**ADDR_W - 1
    localparam int ADDR_W_DEF = 10;

    // Smallest frame dimension that still contains a full 3x3 window
    localparam int MIN_DIM = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/conv_window_sequencer_frame_pos_counter.sv
// rtl/conv_window_sequencer_frame_pos_counter.sv - raster row/column position with wrap and last-pixel detect
module frame_pos_counter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] last_col,
    input  logic [ADDR_W-1:0] last_row,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              is_last
);

    // Step one pixel in raster order; col wraps at the end of each line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == last_col) begin
                col <= '0;
                row <= row + ADDR_W'(1);
            end else begin
                col <= col + ADDR_W'(1);
            end
        end
    end

    // Current position is the final pixel of the frame
    always_comb begin
        is_last = (row == last_row) && (col == last_col);
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - frame sequencer driving the 3x3 window shift/line-buffer enables
module conv_window_sequencer
    import conv_window_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_w,
    input  logic [ADDR_W-1:0] img_h,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              out_stall,
    output logic              shifting,
    output logic              lb_wr_en,
    output logic              lb_rd_en,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_row,
    output logic [ADDR_W-1:0] win_col,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [ADDR_W-1:0] w_q;
    logic [ADDR_W-1:0] h_q;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              is_last;
    logic              cfg_ok;
    logic              start_ok;
    logic              accept;

    assign cfg_ok   = (img_w >= ADDR_W'(MIN_DIM)) && (img_h >= ADDR_W'(MIN_DIM));
    assign start_ok = (state == ST_IDLE) && start && cfg_ok;
    assign accept   = pix_valid && pix_ready;

    // Row/column tracking; cleared on a good start, stepped on each accept
    frame_pos_counter #(
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .advance  (accept),
        .last_col (w_q - ADDR_W'(1)),
        .last_row (h_q - ADDR_W'(1)),
        .row      (row),
        .col      (col),
        .is_last  (is_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start only matters in IDLE, final accept ends the frame
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_RUN;
            ST_RUN:  if (accept && is_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM-decoded outputs; the datapath enables all follow the accept
    always_comb begin
        pix_ready = (state == ST_RUN) && !out_stall;
        busy      = (state == ST_RUN);
        done      = (state == ST_DONE);
        shifting  = accept;
        lb_wr_en  = accept;
        lb_rd_en  = accept && (row != '0);
    end

    // Frame dimensions captured once per accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            h_q <= '0;
        end else if (start_ok) begin
            w_q <= img_w;
            h_q <= img_h;
        end
    end

    // One-cycle error pulse for a start carrying a too-small frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == ST_IDLE) && start && !cfg_ok;
        end
    end

    // Window flag lines up with the shift registers after the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (accept && (row >= ADDR_W'(2)) && (col >= ADDR_W'(2))) begin
            win_valid <= 1'b1;
            win_row   <= row - ADDR_W'(2);
            win_col   <= col - ADDR_W'(2);
        end else begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - self-checking bench for conv_window_sequencer
module tb_conv_window_sequencer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] img_w = '0;
    logic [AW-1:0] img_h = '0;
    logic          pix_valid = 1'b0;
    logic          out_stall = 1'b0;
    logic          pix_ready;
    logic          shifting;
    logic          lb_wr_en;
    logic          lb_rd_en;
    logic          win_valid;
    logic [AW-1:0] win_row;
    logic [AW-1:0] win_col;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int n_pass  = 0;
    int n_total = 0;

    conv_window_sequencer #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .img_w     (img_w),
        .img_h     (img_h),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .out_stall (out_stall),
        .shifting  (shifting),
        .lb_wr_en  (lb_wr_en),
        .lb_rd_en  (lb_rd_en),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_shifting"}, shifting, 0);
        chk({tag, "_lb_wr_en"}, lb_wr_en, 0);
        chk({tag, "_lb_rd_en"}, lb_rd_en, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_win_col"}, win_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Reference: pixel k of a w-wide frame sits at (k/w, k%w); a window
    // completes on that pixel when both coordinates are at least 2.
    task automatic run_frame(input int w, input int h, input bit rnd,
                             input int stall_at, input int stall_len,
                             input int restart_at, input int abort_at);
        int  k = 0;
        int  wins = 0;
        int  cyc = 0;
        int  stalled = 0;
        bit  restarted = 0;
        bit  acc;
        int  r;
        int  c;
        img_w = AW'(w);
        img_h = AW'(h);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (k < w * h && k != abort_at) begin
            if (cyc > 5000) begin
                chk("frame_timeout", 0, 1);
                break;
            end
            cyc++;
            if (rnd) begin
                pix_valid = ($urandom % 4) != 0;
                out_stall = ($urandom % 5) == 0;
            end else begin
                pix_valid = 1'b1;
                out_stall = (k == stall_at) && (stalled < stall_len);
                if (out_stall) stalled++;
            end
            if (k == restart_at && !restarted) begin
                start     = 1'b1;
                img_w     = AW'(7);
                img_h     = AW'(9);
                restarted = 1;
            end
            #1;
            acc = pix_valid && !out_stall;
            r = k / w;
            c = k % w;
            chk("pix_ready", pix_ready, !out_stall);
            chk("shifting", shifting, acc);
            chk("lb_wr_en", lb_wr_en, acc);
            chk("lb_rd_en", lb_rd_en, acc && (r != 0));
            step();
            start = 1'b0;
            if (acc && r >= 2 && c >= 2) begin
                chk("win_valid_hi", win_valid, 1);
                chk("win_row", win_row, r - 2);
                chk("win_col", win_col, c - 2);
                wins++;
            end else begin
                chk("win_valid_lo", win_valid, 0);
            end
            if (acc) k++;
            if (k == w * h) begin
                chk("done_at_end", done, 1);
                chk("busy_at_end", busy, 0);
            end else begin
                chk("done_mid", done, 0);
                chk("busy_mid", busy, 1);
            end
        end
        pix_valid = 1'b0;
        out_stall = 1'b0;
        if (k == w * h) begin
            chk("window_count", wins, (w - 2) * (h - 2));
            step();
            chk("done_one_cycle", done, 0);
            chk("idle_pix_ready", pix_ready, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // 4x4 plain frame
        run_frame(4, 4, 0, -1, 0, -1, -1);

        // 5x3 with a 3-cycle stall after pixel 7
        run_frame(5, 3, 0, 7, 3, -1, -1);

        // Too-small widths/heights are rejected
        img_w = AW'(2);
        img_h = AW'(8);
        start = 1'b1;
        pix_valid = 1'b1;
        #1;
        chk("cfg_pix_ready", pix_ready, 0);
        chk("cfg_shifting", shifting, 0);
        step();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_busy", busy, 0);
        chk("cfg_shifting2", shifting, 0);
        step();
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_busy2", busy, 0);
        img_w = AW'(6);
        img_h = AW'(2);
        start = 1'b1;
        step();
        start = 1'b0;
        pix_valid = 1'b0;
        chk("cfg_err_h", cfg_err, 1);
        chk("cfg_busy_h", busy, 0);
        step();

        // 3x3 frame for line-buffer read timing, with a mid-frame start
        run_frame(3, 3, 0, -1, 0, -1, -1);
        run_frame(4, 4, 0, -1, 0, 5, -1);

        // Asynchronous reset after 9 pixels of a 4x4 frame
        run_frame(4, 4, 0, -1, 0, -1, 9);
        pix_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        pix_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_frame(4, 4, 0, -1, 0, -1, -1);

        // Random handshake over random dimensions
        for (int i = 0; i < 6; i++) begin
            run_frame(3 + int'($urandom % 6), 3 + int'($urandom % 6), 1, -1, 0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
